// File: rtl/mult_pkg.sv
// Shared select codes and types for the clocked 4:1 multiplexer.
// Imported by the interface, the combinational selector and the top.
package mult_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_IN1 = 2'b00;
    localparam sel_t SEL_IN2 = 2'b01;
    localparam sel_t SEL_IN3 = 2'b10;
    localparam sel_t SEL_IN4 = 2'b11;

    // Deepest register chain the top will build.
    localparam int MAX_PIPE_STAGES = 4;

endpackage

// File: rtl/mult_4to1_if.sv
// Data/select bundle between the producers, which drive the four inputs and sel,
// and the multiplexer, which drives out.
interface mult_4to1_if
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    sel_t             sel;
    logic [WIDTH-1:0] out;

    modport master (
        output in1,
        output in2,
        output in3,
        output in4,
        output sel,
        input  out
    );

    modport slave (
        input  in1,
        input  in2,
        input  in3,
        input  in4,
        input  sel,
        output out
    );

endinterface

// File: rtl/mux4_comb.sv
// Combinational 4:1 selector. The select map is complete, so every sel value
// picks a real input and no don't-care value can reach the output.
module mux4_comb
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  sel_t             sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in1;
        unique case (sel)
            SEL_IN1: out = in1;
            SEL_IN2: out = in2;
            SEL_IN3: out = in3;
            SEL_IN4: out = in4;
        endcase
    end

endmodule

// File: rtl/mult_4to1.sv
// Clocked 4:1 multiplexer. It selects one input combinationally, then passes the
// result through PIPE_STAGES resettable registers. PIPE_STAGES=0 gives a plain mux.
module mult_4to1
    import mult_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 1
) (
    input  logic         clk,
    input  logic         rst,
    mult_4to1_if.slave   bus
);

    logic [WIDTH-1:0] sel_data;

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in1 (bus.in1),
        .in2 (bus.in2),
        .in3 (bus.in3),
        .in4 (bus.in4),
        .sel (bus.sel),
        .out (sel_data)
    );

    if (PIPE_STAGES > MAX_PIPE_STAGES || PIPE_STAGES < 0) begin : g_bad_depth
        $error("mult_4to1: PIPE_STAGES=%0d outside 0..%0d", PIPE_STAGES, MAX_PIPE_STAGES);
    end

    if ($bits(bus.out) != WIDTH) begin : g_bad_width
        $error("mult_4to1: interface width %0d differs from WIDTH=%0d", $bits(bus.out), WIDTH);
    end

    if (PIPE_STAGES == 0) begin : g_comb
        // No state exists in this build, so the clock and reset are deliberately left unused.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign bus.out = sel_data;
    end else begin : g_pipe
        for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] data_reg;
            logic [WIDTH-1:0] data_next;

            if (gi == 0) begin : g_head
                assign data_next = sel_data;
            end else begin : g_link
                assign data_next = g_stage[gi-1].data_reg;
            end

            // Reset clears every stage, so in-flight selections never reappear afterwards.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else begin
                    data_reg <= data_next;
                end
            end
        end

        assign bus.out = g_stage[PIPE_STAGES-1].data_reg;
    end

endmodule

// File: tb/tb_mult_4to1.sv
// Scoreboard bench for mult_4to1. It drives three builds (PIPE_STAGES 1, 0 and 3)
// with the same stimulus and compares each against a queue-based delay-line model.
module tb_mult_4to1;
    import mult_pkg::*;

    localparam int W = 32;
    localparam int N = 3;
    localparam int LAT [N] = '{1, 0, 3};

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d_in [4];
    sel_t         d_sel;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    always #5 clk = ~clk;

    mult_4to1_if #(.WIDTH(W)) bus_p1 ();
    mult_4to1_if #(.WIDTH(W)) bus_p0 ();
    mult_4to1_if #(.WIDTH(W)) bus_p3 ();

    assign bus_p1.in1 = d_in[0];
    assign bus_p1.in2 = d_in[1];
    assign bus_p1.in3 = d_in[2];
    assign bus_p1.in4 = d_in[3];
    assign bus_p1.sel = d_sel;
    assign bus_p0.in1 = d_in[0];
    assign bus_p0.in2 = d_in[1];
    assign bus_p0.in3 = d_in[2];
    assign bus_p0.in4 = d_in[3];
    assign bus_p0.sel = d_sel;
    assign bus_p3.in1 = d_in[0];
    assign bus_p3.in2 = d_in[1];
    assign bus_p3.in3 = d_in[2];
    assign bus_p3.in4 = d_in[3];
    assign bus_p3.sel = d_sel;

    mult_4to1 #(.WIDTH(W), .PIPE_STAGES(1)) dut_p1 (.clk(clk), .rst(rst), .bus(bus_p1));
    mult_4to1 #(.WIDTH(W), .PIPE_STAGES(0)) dut_p0 (.clk(clk), .rst(rst), .bus(bus_p0));
    mult_4to1 #(.WIDTH(W), .PIPE_STAGES(3)) dut_p3 (.clk(clk), .rst(rst), .bus(bus_p3));

    logic [W-1:0] outs [N];
    assign outs[0] = bus_p1.out;
    assign outs[1] = bus_p0.out;
    assign outs[2] = bus_p3.out;

    // Reference: out after an edge is the selection sampled LAT-1 edges earlier.
    // A reset edge zeroes the whole delay line.
    logic [W-1:0] pipe_m [N][$];
    logic [W-1:0] exp_q  [N][$];
    logic [W-1:0] last_exp [N];

    initial begin : model
        logic [W-1:0] chosen;
        logic [W-1:0] e;
        for (int d = 0; d < N; d++)
            for (int k = 0; k < LAT[d]; k++) pipe_m[d].push_back('0);
        forever begin
            @(posedge clk);
            chosen = d_in[int'(d_sel)];
            for (int d = 0; d < N; d++) begin
                if (LAT[d] == 0) begin
                    e = chosen;
                end else if (rst) begin
                    pipe_m[d].delete();
                    for (int k = 0; k < LAT[d]; k++) pipe_m[d].push_back('0);
                    e = '0;
                end else begin
                    void'(pipe_m[d].pop_front());
                    pipe_m[d].push_back(chosen);
                    e = pipe_m[d][0];
                end
                exp_q[d].push_back(e);
            end
        end
    end

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            for (int d = 0; d < N; d++) begin
                total++;
                if (exp_q[d].size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_empty_p%0d cycle %0d: got out=%h with no expected entry", LAT[d], cycle, outs[d]);
                end else begin
                    e = exp_q[d].pop_front();
                    last_exp[d] = e;
                    if (outs[d] !== e) begin
                        bad++;
                        $display("FAIL out_p%0d cycle %0d: got %h want %h", LAT[d], cycle, outs[d], e);
                    end else begin
                        $display("cycle %0d p%0d rst=%0b sel=%0d out=%h ok", cycle, LAT[d], rst, d_sel, outs[d]);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] x, input sel_t s);
        @(negedge clk);
        rst     = r;
        d_in[0] = a;
        d_in[1] = b;
        d_in[2] = c;
        d_in[3] = x;
        d_sel   = s;
    endtask

    initial begin : stimulus
        sel_t saved_sel;
        logic [W-1:0] saved_in2;
        rst   = 1'b1;
        d_sel = SEL_IN1;
        for (int i = 0; i < 4; i++) d_in[i] = '0;

        // reset with arbitrary inputs, then the 0/1 pattern
        cyc(1'b1, $urandom, $urandom, $urandom, $urandom, 2'($urandom));
        cyc(1'b1, $urandom, $urandom, $urandom, $urandom, 2'($urandom));
        cyc(1'b0, 32'd0, 32'd1, 32'd0, 32'd1, SEL_IN1);
        cyc(1'b0, 32'd0, 32'd1, 32'd0, 32'd1, SEL_IN2);
        cyc(1'b0, 32'd0, 32'd1, 32'd0, 32'd1, SEL_IN3);
        cyc(1'b0, 32'd0, 32'd1, 32'd0, 32'd1, SEL_IN4);

        // full-width patterns
        for (int s = 0; s < 4; s++)
            cyc(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001, sel_t'(s));

        // reset while a 1 is in flight
        cyc(1'b0, 32'd0, 32'd1, 32'd0, 32'd1, SEL_IN4);
        cyc(1'b0, 32'd0, 32'd1, 32'd0, 32'd1, SEL_IN4);
        cyc(1'b1, 32'd0, 32'd1, 32'd0, 32'd1, SEL_IN4);
        for (int k = 0; k < 4; k++) cyc(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, SEL_IN1);

        // glitch between edges must not reach registered outputs
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 32'hA5A5_0000, 32'h0F0F_F0F0, 32'h1111_2222, 32'h3333_4444, SEL_IN1);
            saved_sel = d_sel;
            saved_in2 = d_in[1];
            #1;
            d_sel   = SEL_IN2;
            d_in[1] = 32'hBAD0_BAD0;
            #1;
            total++;
            if (outs[0] !== last_exp[0]) begin
                bad++;
                $display("FAIL glitch_p1 cycle %0d: got %h want %h", cycle, outs[0], last_exp[0]);
            end
            total++;
            if (outs[2] !== last_exp[2]) begin
                bad++;
                $display("FAIL glitch_p3 cycle %0d: got %h want %h", cycle, outs[2], last_exp[2]);
            end
            #1;
            d_sel   = saved_sel;
            d_in[1] = saved_in2;
        end

        // randomized traffic with occasional resets
        for (int k = 0; k < 200; k++)
            cyc(($urandom_range(0, 19) == 0), $urandom, $urandom, $urandom, $urandom, 2'($urandom));

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
